// File: rtl/bf16_mul_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_mul_arbiter
//
// Shares one registered, fixed-latency bf16 multiplier among N requesters.
// A round-robin arbiter issues at most one operand pair per cycle. A small
// tag pipeline follows each issue through the multiplier, so the result is
// returned to the requester that issued it.
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous active-high reset
//   i_en           global issue enable (in-flight results still return)
//   i_req_valid    [N]      requester i has operands
//   o_req_ready    [N]      one-hot grant; accept = valid & ready
//   i_req_a/b      [16*N]   bf16 operands, slice i = [16i+15:16i]
//   o_mul_a/b      [16]     operands to the multiplier (zero when idle)
//   i_mul_c        [16]     multiplier result
//   o_resp_valid   [N]      one-hot result strobe for the issuing requester
//   o_resp_data    [16]     result, meaningful only while o_resp_valid != 0
//   o_busy                  any issue still travelling through the multiplier
//   o_issue_cnt    [CNT_W]  total accepted issues, wraps
// ---------------------------------------------------------------------------
module bf16_mul_arbiter #(
    parameter int N       = 4,
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [N-1:0]       i_req_valid,
    output logic [N-1:0]       o_req_ready,
    input  logic [16*N-1:0]    i_req_a,
    input  logic [16*N-1:0]    i_req_b,
    output logic [15:0]        o_mul_a,
    output logic [15:0]        o_mul_b,
    input  logic [15:0]        i_mul_c,
    output logic [N-1:0]       o_resp_valid,
    output logic [15:0]        o_resp_data,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_issue_cnt
);

    localparam int ID_W = $clog2(N);
    localparam int TAIL = MUL_LAT - 1;

    logic [ID_W-1:0]  r_rr_ptr;
    logic [MUL_LAT-1:0] r_tag_vld;
    logic [ID_W-1:0]  r_tag_id [MUL_LAT];
    logic [CNT_W-1:0] r_issue_cnt;

    logic             w_grant;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W:0]    w_scan;
    logic [ID_W-1:0]  w_next_ptr;

    // Round-robin search starting at r_rr_ptr. The scan index is one bit
    // wider than an id so the wrap past N-1 can be done with a subtract,
    // which also works when N is not a power of two.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_id = '0;
        w_scan     = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(N)) begin
                w_scan = w_scan - (ID_W+1)'(N);
            end
            if (!w_grant && i_en && i_req_valid[w_scan[ID_W-1:0]]) begin
                w_grant    = 1'b1;
                w_grant_id = w_scan[ID_W-1:0];
            end
        end
    end

    // One-hot ready and operand mux; operands are forced to zero when
    // nothing is granted so the multiplier sees a clean input while idle.
    always_comb begin
        o_req_ready = '0;
        o_mul_a     = 16'h0000;
        o_mul_b     = 16'h0000;
        for (int i = 0; i < N; i++) begin
            if (w_grant && (w_grant_id == ID_W'(i))) begin
                o_req_ready[i] = 1'b1;
                o_mul_a        = i_req_a[16*i +: 16];
                o_mul_b        = i_req_b[16*i +: 16];
            end
        end
    end

    assign w_next_ptr = (w_grant_id == ID_W'(N-1)) ? '0 : w_grant_id + ID_W'(1);

    // Pointer, tag pipeline and issue counter. Since ready is only raised
    // for a valid requester, a grant is always an accept. Reset clears the
    // tag valid bits so results of discarded issues are never signalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr    <= '0;
            r_tag_vld   <= '0;
            r_issue_cnt <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_grant;
            r_tag_id[0]  <= w_grant_id;
            for (int s = 1; s < MUL_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
            if (w_grant) begin
                r_rr_ptr    <= w_next_ptr;
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
        end
    end

    // The tag at the pipe tail lines up with the multiplier output, so the
    // response strobe is decoded from it and the data is passed straight on.
    always_comb begin
        o_resp_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (r_tag_vld[TAIL] && (r_tag_id[TAIL] == ID_W'(i))) begin
                o_resp_valid[i] = 1'b1;
            end
        end
    end

    assign o_resp_data = i_mul_c;
    assign o_busy      = |r_tag_vld;
    assign o_issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bf16_mul_arbiter
//
// Directed bench for bf16_mul_arbiter. Two instances share all request-side
// inputs: dut1 has a one-cycle multiplier, dut3 a three-cycle one (with a
// 4-bit issue counter so counter wrap is reachable). Each instance is fed by
// its own small bf16 multiplier model. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_bf16_mul_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  reqValid;
    logic [63:0] reqA;
    logic [63:0] reqB;

    logic [3:0]  reqReady1, respValid1, reqReady3, respValid3;
    logic [15:0] mulA1, mulB1, mulC1, respData1;
    logic [15:0] mulA3, mulB3, mulC3, respData3;
    logic        busy1, busy3;
    logic [15:0] issueCnt1;
    logic [3:0]  issueCnt3;

    int compareCount;
    int mismatchCount;

    bf16_mul_arbiter #(.N(4), .MUL_LAT(1), .CNT_W(16)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_req_valid(reqValid), .o_req_ready(reqReady1),
        .i_req_a(reqA), .i_req_b(reqB),
        .o_mul_a(mulA1), .o_mul_b(mulB1), .i_mul_c(mulC1),
        .o_resp_valid(respValid1), .o_resp_data(respData1),
        .o_busy(busy1), .o_issue_cnt(issueCnt1)
    );

    bf16_mul_arbiter #(.N(4), .MUL_LAT(3), .CNT_W(4)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_req_valid(reqValid), .o_req_ready(reqReady3),
        .i_req_a(reqA), .i_req_b(reqB),
        .o_mul_a(mulA3), .o_mul_b(mulB3), .i_mul_c(mulC3),
        .o_resp_valid(respValid3), .o_resp_data(respData3),
        .o_busy(busy3), .o_issue_cnt(issueCnt3)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating bf16 multiply for normal operands; zero/denormal inputs
    // give a signed zero. Good enough to stand in for the real multiplier.
    function automatic logic [15:0] mulModel(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] m;
        logic [8:0]  e;
        logic        s;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'h00 || b[14:7] == 8'h00) return {s, 15'h0000};
        m = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
        e = {1'b0, a[14:7]} + {1'b0, b[14:7]} - 9'd127;
        if (m[15]) begin
            e = e + 9'd1;
            return {s, e[7:0], m[14:8]};
        end
        return {s, e[7:0], m[13:7]};
    endfunction

    // Multiplier models: operands captured at the edge, result visible
    // after one edge (dut1) or three edges (dut3).
    logic [15:0] mulPipe1;
    logic [15:0] mulPipe3 [3];
    always @(posedge clk) begin
        mulPipe1    <= mulModel(mulA1, mulB1);
        mulPipe3[0] <= mulModel(mulA3, mulB3);
        mulPipe3[1] <= mulPipe3[0];
        mulPipe3[2] <= mulPipe3[1];
    end
    assign mulC1 = mulPipe1;
    assign mulC3 = mulPipe3[2];

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives the shared request-side inputs and lets combinational outputs settle.
    task automatic applyStimulus(input logic enV, input logic [3:0] validV, input logic rstV);
        en       = enV;
        reqValid = validV;
        rst      = rstV;
        #2;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAll();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] prodTab [4];
    logic [3:0]  readyExp4 [7];
    logic [3:0]  respExp4  [7];
    logic        busyExp4  [7];
    logic [15:0] dataExp4  [7];
    logic [3:0]  validSeq3 [6];
    logic [3:0]  readySeq3 [6];

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reqA = '0;
        reqB = '0;
        rst  = 1'b1;
        en   = 1'b0;
        reqValid = 4'b0000;
        tick();

        // ---- Test 1: single issue, one-cycle multiplier ----
        resetAll();
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t1_rst_resp", 32'(respValid1), 32'h0);
        checkOutput("t1_rst_busy", 32'(busy1), 32'h0);
        checkOutput("t1_rst_cnt", 32'(issueCnt1), 32'h0);
        checkOutput("t1_rst_ready", 32'(reqReady1), 32'h0);
        reqA[15:0] = 16'h3F80;
        reqB[15:0] = 16'h4000;
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("t1_ready", 32'(reqReady1), 32'h1);
        checkOutput("t1_mul_a", 32'(mulA1), 32'h3F80);
        checkOutput("t1_mul_b", 32'(mulB1), 32'h4000);
        tick();
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t1_resp", 32'(respValid1), 32'h1);
        checkOutput("t1_data", 32'(respData1), 32'h4000);
        checkOutput("t1_cnt", 32'(issueCnt1), 32'h1);
        checkOutput("t1_busy", 32'(busy1), 32'h1);
        tick();
        #2;
        checkOutput("t1_resp_after", 32'(respValid1), 32'h0);
        checkOutput("t1_busy_after", 32'(busy1), 32'h0);

        // ---- Test 2: all four requesting, rotating grants ----
        resetAll();
        prodTab[0] = 16'h4000;
        prodTab[1] = 16'h4040;
        prodTab[2] = 16'h4080;
        prodTab[3] = 16'h40A0;
        for (int i = 0; i < 4; i++) begin
            reqA[16*i +: 16] = 16'h3F80;
            reqB[16*i +: 16] = prodTab[i];
        end
        applyStimulus(1'b1, 4'b1111, 1'b0);
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("t2_ready_c%0d", c), 32'(reqReady1), 32'(4'b0001 << (c % 4)));
            if (c > 0) begin
                checkOutput($sformatf("t2_resp_c%0d", c), 32'(respValid1), 32'(4'b0001 << ((c-1) % 4)));
                checkOutput($sformatf("t2_data_c%0d", c), 32'(respData1), 32'(prodTab[(c-1) % 4]));
            end
            tick();
            #2;
        end
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t2_resp_last", 32'(respValid1), 32'h8);
        checkOutput("t2_data_last", 32'(respData1), 32'h40A0);
        checkOutput("t2_cnt", 32'(issueCnt1), 32'h8);

        // ---- Test 3: fairness with req0 held and req2 arriving late ----
        resetAll();
        validSeq3[0] = 4'b0001; readySeq3[0] = 4'b0001;
        validSeq3[1] = 4'b0001; readySeq3[1] = 4'b0001;
        validSeq3[2] = 4'b0001; readySeq3[2] = 4'b0001;
        validSeq3[3] = 4'b0101; readySeq3[3] = 4'b0100;
        validSeq3[4] = 4'b0101; readySeq3[4] = 4'b0001;
        validSeq3[5] = 4'b0101; readySeq3[5] = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, validSeq3[c], 1'b0);
            checkOutput($sformatf("t3_ready_c%0d", c), 32'(reqReady1), 32'(readySeq3[c]));
            tick();
        end

        // ---- Test 4: three-cycle multiplier, issues from ids 1,3,0 ----
        resetAll();
        reqA = '0;
        reqB = '0;
        reqA[16 +: 16] = 16'h3F80; reqB[16 +: 16] = 16'h4040;
        reqA[48 +: 16] = 16'h4000; reqB[48 +: 16] = 16'h4000;
        reqA[0  +: 16] = 16'h3FC0; reqB[0  +: 16] = 16'h4040;
        readyExp4 = '{4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        respExp4  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0001, 4'b0000};
        busyExp4  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        dataExp4  = '{16'h0, 16'h0, 16'h0, 16'h4040, 16'h4080, 16'h4090, 16'h0};
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, (c < 3) ? readyExp4[c] : 4'b0000, 1'b0);
            checkOutput($sformatf("t4_ready_c%0d", c), 32'(reqReady3), 32'(readyExp4[c]));
            checkOutput($sformatf("t4_resp_c%0d", c), 32'(respValid3), 32'(respExp4[c]));
            checkOutput($sformatf("t4_busy_c%0d", c), 32'(busy3), 32'(busyExp4[c]));
            if (c >= 3 && c <= 5) begin
                checkOutput($sformatf("t4_data_c%0d", c), 32'(respData3), 32'(dataExp4[c]));
            end
            tick();
        end
        #2;
        checkOutput("t4_cnt", 32'(issueCnt3), 32'h3);

        // ---- Test 5: issue, then drop enable; result must still arrive ----
        reqA[32 +: 16] = 16'h4000;
        reqB[32 +: 16] = 16'h4040;
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkOutput("t5_ready_issue", 32'(reqReady3), 32'h4);
        tick();
        for (int c = 1; c < 5; c++) begin
            applyStimulus(1'b0, 4'b1111, 1'b0);
            checkOutput($sformatf("t5_ready_c%0d", c), 32'(reqReady3), 32'h0);
            checkOutput($sformatf("t5_mul_a_c%0d", c), 32'(mulA3), 32'h0);
            checkOutput($sformatf("t5_mul_b_c%0d", c), 32'(mulB3), 32'h0);
            checkOutput($sformatf("t5_resp_c%0d", c), 32'(respValid3), (c == 3) ? 32'h4 : 32'h0);
            if (c == 3) begin
                checkOutput("t5_data", 32'(respData3), 32'h40C0);
            end
            tick();
        end
        #2;
        checkOutput("t5_cnt", 32'(issueCnt3), 32'h4);

        // ---- Test 6: reset one cycle after an issue discards it ----
        applyStimulus(1'b1, 4'b0010, 1'b0);
        checkOutput("t6_ready_issue", 32'(reqReady3), 32'h2);
        tick();
        applyStimulus(1'b1, 4'b0000, 1'b1);
        tick();
        for (int c = 2; c < 5; c++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0);
            checkOutput($sformatf("t6_resp_c%0d", c), 32'(respValid3), 32'h0);
            checkOutput($sformatf("t6_busy_c%0d", c), 32'(busy3), 32'h0);
            checkOutput($sformatf("t6_cnt_c%0d", c), 32'(issueCnt3), 32'h0);
            tick();
        end
        applyStimulus(1'b1, 4'b1010, 1'b0);
        checkOutput("t6_ready_after", 32'(reqReady3), 32'h2);
        tick();

        // ---- Issue counter wrap on the 4-bit instance ----
        applyStimulus(1'b1, 4'b1111, 1'b0);
        for (int c = 0; c < 15; c++) begin
            tick();
        end
        #2;
        checkOutput("cnt_wrap_zero", 32'(issueCnt3), 32'h0);
        tick();
        #2;
        checkOutput("cnt_wrap_one", 32'(issueCnt3), 32'h1);
        applyStimulus(1'b0, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/bf16_mul_arbiter.md
Name: bf16_mul_arbiter

Overview:
- Shares one bf16 multiplier (registered, fixed latency) among N requesters.
- Each requester has an independent valid/ready operand channel.
- Grants are round-robin, at most one issue per cycle.
- A tag pipeline tracks each issue through the multiplier so the result returns to the requester that issued it.
- Sits between the per-lane compute controllers and the single bf16 multiplier instance.

Parameters:
- N, 4, number of requesters (2..8).
- MUL_LAT, 1, multiplier latency in clock edges from operand capture to result visible (≥1).
- CNT_W, 16, width of issue counter.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global issue enable; 0 blocks all grants, in-flight results still return.
- req_valid  in  N  requester i has operands.
- req_ready  out  N  one-hot or zero; requester i accepted this cycle when req_valid[i]&req_ready[i].
- req_a  in  16*N  bf16 operand A, slice i = [16i+15:16i].
- req_b  in  16*N  bf16 operand B, same slicing.
- mul_a  out  16  operand A to multiplier.
- mul_b  out  16  operand B to multiplier.
- mul_c  in  16  multiplier result.
- resp_valid  out  N  one-hot or zero; result for requester i present this cycle.
- resp_data  out  16  result, valid only where resp_valid≠0.
- busy  out  1  any issue in flight.
- issue_cnt  out  CNT_W  total accepted issues, wraps.

Behaviour:
- Reset (sync, rst=1 at edge):
  - rr_ptr=0.
  - All tag-pipe valid bits=0.
  - issue_cnt=0.
  - After the reset edge: resp_valid=0, busy=0, req_ready=0 unless requests are present.
- Arbitration (combinational, same cycle):
  - If en=1 and any req_valid: grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod N.
  - req_ready = onehot(grant).
  - With no grant or en=0: req_ready=0.
- Pointer update at the edge:
  - On accept by i: rr_ptr ← (i+1) mod N.
  - No accept: rr_ptr unchanged.
  - Fairness: a continuously asserted request is served within N accepts.
- Operand mux (combinational):
  - mul_a/mul_b = granted requester's operands.
  - 16'h0000 when there is no grant.
  - The multiplier captures them at the accept edge.
- Tag pipeline:
  - MUL_LAT stages of {vld, id[clog2(N)-1:0]}.
  - Stage0 ← {accept, granted id} at each edge; later stages shift.
  - Accept at edge k → resp_valid[id]=1 for exactly one cycle, the cycle after edge k+MUL_LAT-1.
  - In that cycle resp_data = mul_c (passthrough).
  - No response backpressure: requesters must accept responses unconditionally.
- Throughput: one accept per cycle sustained; back-to-back results are returned in issue order.
- busy = OR of tag-pipe vld bits; it does not include the current-cycle grant.
- issue_cnt increments by 1 per accept and wraps from 2^CNT_W-1 to 0.
- en deassert mid-stream: no new grants; in-flight results still complete.
- Reset mid-operation: in-flight tags are discarded and their results are never signalled; mul_c is ignored until a new issue reaches the pipe tail.
- Simultaneous requests from all N: one grant per cycle, rotating; order from rr_ptr=0 is 0,1,…,N-1.
- Requester dropping valid before grant: no effect; operands are not latched by this block.
- Simultaneous accept and response in the same cycle are independent; different ids are allowed.

Test Plan:
1. Reset, then req_valid=0001 with req_a[0]=16'h3F80 (1.0), req_b[0]=16'h4000 (2.0), MUL_LAT=1 → accept at edge k; resp_valid=0001 and resp_data=16'h4000 in the cycle after edge k; issue_cnt=1; busy=1 for that cycle only.
2. All four req_valid held high for 8 cycles → grants in order 0,1,2,3,0,1,2,3; each resp_valid matches its issue id MUL_LAT edges later; issue_cnt=8.
3. Round-robin fairness: req0 held high continuously, req2 asserted at cycle 3 → req2 granted within 2 accepts, and req0 is not granted twice in a row while req2 is waiting.
4. MUL_LAT=3, back-to-back issues from ids 1,3,0 → resp_valid sequence 0010, 1000, 0001 on consecutive cycles, 3 edges after each accept; resp_data follows mul_c.
5. en=0 with req_valid=1111 → req_ready=0000, mul_a=mul_b=0; dropping en one cycle after an issue still delivers that result.
6. rst asserted one cycle after an issue with MUL_LAT=3 → no resp_valid for that issue; busy=0, rr_ptr=0, issue_cnt=0 after the reset edge; next grant goes to the lowest valid id.
